shift_sequencer: RTL and testbench

Multi-cycle shift unit for the ALU's shift instructions (sll/srl/sra, plus rotate-left). It iterates a small step datapath that shifts by 2 or 1 bit per clock until the requested amount is consumed. It sits beside the ALU in the multi-cycle datapath and is started by the main control FSM with a start/ready/done handshake. Area is traded for latency: a 5-bit amount costs at most 16 step cycles instead of a full barrel shifter.

---
 rtl/shift_sequencer_pkg.sv | 17 +
 rtl/shift_sequencer_step.sv | 33 +++
 rtl/shift_sequencer.sv | 92 +++++++++
 tb/tb_shift_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: operation codes and FSM states.
// Imported by the control FSM, the step datapath and the testbench so that
// every party decodes op and state identically.
package shift_sequencer_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_step.sv
// One combinational shift step of 1 or 2 bit positions.
// Ports:
//   i_acc  - current working value
//   i_op   - operation (OP_SLL/OP_SRL/OP_SRA/OP_ROL)
//   i_sel2 - 1: step by 2, 0: step by 1
//   o_acc  - stepped value
module shift_sequencer_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [1:0]       i_op,
  input  logic             i_sel2,
  output logic [WIDTH-1:0] o_acc
);

  always_comb begin
    o_acc = i_acc;
    case (i_op)
      OP_SLL: o_acc = i_sel2 ? {i_acc[WIDTH-3:0], 2'b00}
                             : {i_acc[WIDTH-2:0], 1'b0};
      OP_SRL: o_acc = i_sel2 ? {2'b00, i_acc[WIDTH-1:2]}
                             : {1'b0, i_acc[WIDTH-1:1]};
      OP_SRA: o_acc = i_sel2 ? {{2{i_acc[WIDTH-1]}}, i_acc[WIDTH-1:2]}
                             : {i_acc[WIDTH-1], i_acc[WIDTH-1:1]};
      OP_ROL: o_acc = i_sel2 ? {i_acc[WIDTH-3:0], i_acc[WIDTH-1:WIDTH-2]}
                             : {i_acc[WIDTH-2:0], i_acc[WIDTH-1]};
      default: o_acc = i_acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter (sll/srl/sra/rol). Consumes the shift amount 2 bits per
// clock (1 on the final odd step), so a shamt of n costs ceil(n/2) cycles.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   start         - request, taken only while ready=1
//   op, shamt     - operation and unsigned shift amount
//   data_in       - operand
//   ready         - a start can be accepted (IDLE or DONE)
//   busy          - stepping (SHIFT)
//   done          - one-cycle pulse, result valid
//   result        - working register, held until the next accepted start
//   o_dbg_state   - current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where start=1 and ready=1.
// ready is decoded from the state register only, so it never depends on start
// in the same cycle; start while ready=0 is dropped, never queued. A start in
// the DONE cycle is accepted, giving back-to-back operation.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       o_dbg_state
);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [SHW-1:0]   r_rem;
  logic [WIDTH-1:0] r_acc;

  logic             w_sel2;
  logic [SHW-1:0]   w_rem_next;
  logic [WIDTH-1:0] w_step;

  // Take a double step whenever at least two positions remain; the last odd
  // position is a single step that drains rem to zero.
  assign w_sel2     = (r_rem > SHW'(1));
  assign w_rem_next = w_sel2 ? (r_rem - SHW'(2)) : '0;

  shift_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .i_acc  (r_acc),
    .i_op   (r_op),
    .i_sel2 (w_sel2),
    .o_acc  (w_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SLL;
      r_rem   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op    <= op;
            r_acc   <= data_in;
            r_rem   <= shamt;
            r_state <= (shamt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_step;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready       = (r_state != ST_SHIFT);
  assign busy        = (r_state == ST_SHIFT);
  assign done        = (r_state == ST_DONE);
  assign result      = r_acc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed vectors plus randomized operations,
// scored against a plain-arithmetic reference model through an expected queue.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [1:0]   op      = 2'b00;
  logic [4:0]   shamt   = 5'd0;
  logic [W-1:0] data_in = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequencer #(.WIDTH(W), .SHW(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .shamt       (shamt),
    .data_in     (data_in),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           checks   = 0;
  int           errors   = 0;
  int           busy_cnt = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           exp_n_q[$];
  logic [W-1:0] last_exp = '0;
  logic [W-1:0] mon_e;
  int           mon_c;
  int           mon_n;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the whole shift in one arithmetic expression.
  function automatic logic [W-1:0] model(input logic [1:0] o,
                                         input logic [W-1:0] d, input int s);
    case (o)
      OP_SLL:  return d << s;
      OP_SRL:  return d >> s;
      OP_SRA:  return W'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d << s) | (d >> (W - s)));
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result 0x%08h, nothing outstanding", result);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          mon_n = exp_n_q.pop_front();
          check("result", result, mon_e);
          check("done_cycle", W'(cyc), W'(mon_c + mon_n));
          check("busy_cycles", W'(busy_cnt), W'(mon_n));
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] d,
                       input logic [4:0] s, input logic [W-1:0] e);
    int guard = 0;
    while (!ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: ready stayed 0 for %0d cycles", guard);
    end
    op      = o;
    data_in = d;
    shamt   = s;
    start   = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc);
    exp_n_q.push_back((int'(s) + 1) / 2);
    last_exp = e;
    start   = 1'b0;
    op      = 2'($urandom);
    data_in = $urandom;
    shamt   = 5'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", guard);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   r_o;
    logic [W-1:0] r_d;
    logic [4:0]   r_s;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    check("rst_ready", W'(ready), 1);
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_result", result, 0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(OP_SLL, 32'h0000_0001, 5'd5, 32'h0000_0020);  wait_done(); @(negedge clk);
    issue(OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF); wait_done(); @(negedge clk);
    issue(OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001); wait_done(); @(negedge clk);
    issue(OP_SRL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);  wait_done(); @(negedge clk);
    issue(OP_ROL, 32'h8000_0001, 5'd1, 32'h0000_0003);  wait_done(); @(negedge clk);
    issue(OP_ROL, 32'h1234_5678, 5'd4, 32'h2345_6781);  wait_done(); @(negedge clk);

    // start pulsed with new operands while busy must be dropped
    issue(OP_SLL, 32'h0000_00FF, 5'd12, 32'h000F_F000);
    @(negedge clk);
    check("busy_ready_low", W'(ready), 0);
    start = 1'b1; op = OP_SRL; data_in = 32'hFFFF_FFFF; shamt = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // back-to-back start in the DONE cycle
    issue(OP_SRA, 32'hF000_0000, 5'd3, 32'hFE00_0000);
    check("b2b_state_shift", W'(dbg_state), W'(ST_SHIFT));
    wait_done();
    repeat (3) @(negedge clk);
    check("idle_state", W'(dbg_state), W'(ST_IDLE));
    check("result_held", result, last_exp);

    // asynchronous reset in the middle of SHIFT
    issue(OP_SLL, 32'hFFFF_FFFF, 5'd20, 32'hFFF0_0000);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_n_q.delete();
    busy_cnt = 0;
    #1;
    check("abort_state", W'(dbg_state), W'(ST_IDLE));
    check("abort_ready", W'(ready), 1);
    check("abort_done", W'(done), 0);
    check("abort_result", result, 0);
    repeat (2) begin
      @(negedge clk);
      check("in_reset_done", W'(done), 0);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(OP_SRL, 32'hF000_000F, 5'd7, 32'h01E0_0000); wait_done(); @(negedge clk);

    // randomized operations, mixed back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      r_o = 2'($urandom_range(0, 3));
      r_d = $urandom;
      r_s = 5'($urandom_range(0, 31));
      issue(r_o, r_d, r_s, model(r_o, r_d, int'(r_s)));
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
